// File: rtl/w_pkg.sv
// Shared constants for the GAN weight set: layer word counts, counter width and
// the loader FSM encoding. The weight ROM and the MAC layers use the same values.
package w_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_N_INPUT = 2;
    localparam int DEF_N_G_L2  = 3;
    localparam int DEF_N_G_L3  = 9;
    localparam int DEF_N_D_L2  = 3;
    localparam int DEF_N_D_L3  = 1;

    localparam int CNT_WG2   = DEF_N_INPUT * DEF_N_G_L2;
    localparam int CNT_WG3   = DEF_N_G_L2 * DEF_N_G_L3;
    localparam int CNT_WD2   = DEF_N_G_L3 * DEF_N_D_L2;
    localparam int CNT_WD3   = DEF_N_D_L2 * DEF_N_D_L3;
    localparam int CNT_TOTAL = CNT_WG2 + CNT_WG3 + CNT_WD2 + CNT_WD3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A one-word layer still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(max4(CNT_WG2, CNT_WG3, CNT_WD2, CNT_WD3));

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_WG2 = 3'd1,
        ST_LOAD_WG3 = 3'd2,
        ST_LOAD_WD2 = 3'd3,
        ST_LOAD_WD3 = 3'd4
    } w_state_e;

    typedef enum logic [1:0] {
        LYR_WG2 = 2'd0,
        LYR_WG3 = 2'd1,
        LYR_WD2 = 2'd2,
        LYR_WD3 = 2'd3
    } w_layer_e;

endpackage

// File: rtl/w_bank.sv
// One weight bank: four packed layer registers with a single word-wide write port.
// Cleared synchronously by reset; reads are the raw registers.
module w_bank
    import w_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_WG2 = CNT_WG2,
    parameter int N_WG3 = CNT_WG3,
    parameter int N_WD2 = CNT_WD2,
    parameter int N_WD3 = CNT_WD3,
    parameter int IDX_W = CNT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_we,
    input  w_layer_e               i_layer,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic [WIDTH-1:0]       i_data,
    output logic [N_WG2*WIDTH-1:0] o_wg2,
    output logic [N_WG3*WIDTH-1:0] o_wg3,
    output logic [N_WD2*WIDTH-1:0] o_wd2,
    output logic [N_WD3*WIDTH-1:0] o_wd3
);

    logic [N_WG2*WIDTH-1:0] r_wg2;
    logic [N_WG3*WIDTH-1:0] r_wg3;
    logic [N_WD2*WIDTH-1:0] r_wd2;
    logic [N_WD3*WIDTH-1:0] r_wd3;

    // Word write into the selected layer slot, decoded per slot so no index can overrun a layer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wg2 <= {(N_WG2*WIDTH){1'b0}};
            r_wg3 <= {(N_WG3*WIDTH){1'b0}};
            r_wd2 <= {(N_WD2*WIDTH){1'b0}};
            r_wd3 <= {(N_WD3*WIDTH){1'b0}};
        end else if (i_we) begin
            case (i_layer)
                LYR_WG2: begin
                    for (int i = 0; i < N_WG2; i++) begin
                        if (i_idx == IDX_W'(i)) r_wg2[i*WIDTH +: WIDTH] <= i_data;
                    end
                end
                LYR_WG3: begin
                    for (int i = 0; i < N_WG3; i++) begin
                        if (i_idx == IDX_W'(i)) r_wg3[i*WIDTH +: WIDTH] <= i_data;
                    end
                end
                LYR_WD2: begin
                    for (int i = 0; i < N_WD2; i++) begin
                        if (i_idx == IDX_W'(i)) r_wd2[i*WIDTH +: WIDTH] <= i_data;
                    end
                end
                LYR_WD3: begin
                    for (int i = 0; i < N_WD3; i++) begin
                        if (i_idx == IDX_W'(i)) r_wd3[i*WIDTH +: WIDTH] <= i_data;
                    end
                end
                default: begin
                    r_wg2 <= r_wg2;
                end
            endcase
        end else begin
            r_wg2 <= r_wg2;
        end
    end

    assign o_wg2 = r_wg2;
    assign o_wg3 = r_wg3;
    assign o_wd2 = r_wd2;
    assign o_wd3 = r_wd3;

endmodule

// File: rtl/w_mem_loader.sv
// Runtime weight loader: streams a full weight set into the hidden bank and swaps
// banks on the last word, so the layers only ever see a complete set.
module w_mem_loader
    import w_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_INPUT = DEF_N_INPUT,
    parameter int N_G_L2  = DEF_N_G_L2,
    parameter int N_G_L3  = DEF_N_G_L3,
    parameter int N_D_L2  = DEF_N_D_L2,
    parameter int N_D_L3  = DEF_N_D_L3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [WIDTH-1:0]              i_s_data,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_choice,
    output logic [N_INPUT*N_G_L2*WIDTH-1:0] o_wg2,
    output logic [N_G_L2*N_G_L3*WIDTH-1:0]  o_wg3,
    output logic [N_G_L3*N_D_L2*WIDTH-1:0]  o_wd2,
    output logic [N_D_L2*N_D_L3*WIDTH-1:0]  o_wd3
);

    localparam int L_WG2 = N_INPUT * N_G_L2;
    localparam int L_WG3 = N_G_L2 * N_G_L3;
    localparam int L_WD2 = N_G_L3 * N_D_L2;
    localparam int L_WD3 = N_D_L2 * N_D_L3;
    localparam int CW    = cnt_width(max4(L_WG2, L_WG3, L_WD2, L_WD3));

    localparam logic [CW-1:0] C_LAST_WG2 = CW'(L_WG2 - 1);
    localparam logic [CW-1:0] C_LAST_WG3 = CW'(L_WG3 - 1);
    localparam logic [CW-1:0] C_LAST_WD2 = CW'(L_WD2 - 1);
    localparam logic [CW-1:0] C_LAST_WD3 = CW'(L_WD3 - 1);
    localparam logic [CW-1:0] C_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE      = CW'(32'd1);

    w_state_e        r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_choice;
    logic            r_done;
    logic            r_busy;

    w_layer_e        w_layer;
    logic [CW-1:0]   w_last_idx;
    w_state_e        w_next_state;
    logic            w_hs;
    logic            w_we0;
    logic            w_we1;

    logic [L_WG2*WIDTH-1:0] w_wg2_b0, w_wg2_b1;
    logic [L_WG3*WIDTH-1:0] w_wg3_b0, w_wg3_b1;
    logic [L_WD2*WIDTH-1:0] w_wd2_b0, w_wd2_b1;
    logic [L_WD3*WIDTH-1:0] w_wd3_b0, w_wd3_b1;

    // Per-state layer target, last word index and successor.
    always_comb begin
        w_layer      = LYR_WG2;
        w_last_idx   = C_LAST_WG2;
        w_next_state = ST_IDLE;
        case (r_state)
            ST_LOAD_WG2: begin
                w_layer      = LYR_WG2;
                w_last_idx   = C_LAST_WG2;
                w_next_state = ST_LOAD_WG3;
            end
            ST_LOAD_WG3: begin
                w_layer      = LYR_WG3;
                w_last_idx   = C_LAST_WG3;
                w_next_state = ST_LOAD_WD2;
            end
            ST_LOAD_WD2: begin
                w_layer      = LYR_WD2;
                w_last_idx   = C_LAST_WD2;
                w_next_state = ST_LOAD_WD3;
            end
            ST_LOAD_WD3: begin
                w_layer      = LYR_WD3;
                w_last_idx   = C_LAST_WD3;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_layer      = LYR_WG2;
                w_last_idx   = C_LAST_WG2;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Abort wins over a same-cycle handshake, so an aborted word never lands.
    assign w_hs  = i_s_valid & r_busy;
    assign w_we0 = w_hs & ~i_abort & r_choice;
    assign w_we1 = w_hs & ~i_abort & ~r_choice;

    // Load sequencer: layer walk, word counter, bank swap and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= C_ZERO;
            r_choice <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= C_ZERO;
                    if (i_start) begin
                        r_state <= ST_LOAD_WG2;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_LOAD_WG2, ST_LOAD_WG3, ST_LOAD_WD2, ST_LOAD_WD3: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= C_ZERO;
                        r_busy  <= 1'b0;
                    end else if (w_hs) begin
                        if (r_cnt == w_last_idx) begin
                            r_cnt   <= C_ZERO;
                            r_state <= w_next_state;
                            if (r_state == ST_LOAD_WD3) begin
                                r_choice <= ~r_choice;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                            end else begin
                                r_choice <= r_choice;
                            end
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= C_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    w_bank #(
        .WIDTH (WIDTH),
        .N_WG2 (L_WG2),
        .N_WG3 (L_WG3),
        .N_WD2 (L_WD2),
        .N_WD3 (L_WD3),
        .IDX_W (CW)
    ) u_bank0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we0),
        .i_layer (w_layer),
        .i_idx   (r_cnt),
        .i_data  (i_s_data),
        .o_wg2   (w_wg2_b0),
        .o_wg3   (w_wg3_b0),
        .o_wd2   (w_wd2_b0),
        .o_wd3   (w_wd3_b0)
    );

    w_bank #(
        .WIDTH (WIDTH),
        .N_WG2 (L_WG2),
        .N_WG3 (L_WG3),
        .N_WD2 (L_WD2),
        .N_WD3 (L_WD3),
        .IDX_W (CW)
    ) u_bank1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we1),
        .i_layer (w_layer),
        .i_idx   (r_cnt),
        .i_data  (i_s_data),
        .o_wg2   (w_wg2_b1),
        .o_wg3   (w_wg3_b1),
        .o_wd2   (w_wd2_b1),
        .o_wd3   (w_wd3_b1)
    );

    assign o_s_ready = r_busy;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_choice  = r_choice;

    assign o_wg2 = r_choice ? w_wg2_b1 : w_wg2_b0;
    assign o_wg3 = r_choice ? w_wg3_b1 : w_wg3_b0;
    assign o_wd2 = r_choice ? w_wd2_b1 : w_wd2_b0;
    assign o_wd3 = r_choice ? w_wd3_b1 : w_wd3_b0;

endmodule

// File: tb/tb_w_mem_loader.sv
// Scoreboard bench for w_mem_loader: each completed load pushes its expected weight
// set and done cycle; a monitor pops and compares on every done pulse.
module tb_w_mem_loader;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [31:0]  i_s_data = 32'd0;
    logic         i_s_valid = 1'b0;
    logic         o_s_ready, o_busy, o_done, o_choice;
    logic [191:0] o_wg2;
    logic [863:0] o_wg3;
    logic [863:0] o_wd2;
    logic [95:0]  o_wd3;

    typedef struct {
        logic [191:0] wg2;
        logic [863:0] wg3;
        logic [863:0] wd2;
        logic [95:0]  wd3;
        logic         ch;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic cur_ch;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    w_mem_loader dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_s_data  (i_s_data),
        .i_s_valid (i_s_valid),
        .o_s_ready (o_s_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_choice  (o_choice),
        .o_wg2     (o_wg2),
        .o_wg3     (o_wg3),
        .o_wd2     (o_wd2),
        .o_wd3     (o_wd3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [863:0] act, input logic [863:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Word k of a load is base+k; layers take words 0-5, 6-32, 33-59, 60-62.
    task automatic build(input logic [31:0] base, output exp_t e);
        e.wg2 = '0; e.wg3 = '0; e.wd2 = '0; e.wd3 = '0; e.ch = 1'b0; e.cyc = 0;
        for (int k = 0; k < 63; k++) begin
            if (k < 6)       e.wg2[k*32 +: 32]      = base + 32'(k);
            else if (k < 33) e.wg3[(k-6)*32 +: 32]  = base + 32'(k);
            else if (k < 60) e.wd2[(k-33)*32 +: 32] = base + 32'(k);
            else             e.wd3[(k-60)*32 +: 32] = base + 32'(k);
        end
    endtask

    // Monitor: every done pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            n_vec++; n_err++;
            $display("FAIL done_missing got=none want=cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (o_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done_unexpected got=done at cycle %0d want=no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 864'(cyc), 864'(e.cyc));
                chk("done_choice", 864'(o_choice), 864'(e.ch));
                chk("done_wg2", 864'(o_wg2), 864'(e.wg2));
                chk("done_wg3", o_wg3, e.wg3);
                chk("done_wd2", o_wd2, e.wd2);
                chk("done_wd3", 864'(o_wd3), 864'(e.wd3));
                chk("done_ready", 864'(o_s_ready), 864'd0);
                chk("done_busy", 864'(o_busy), 864'd0);
            end
        end
    end

    // kind: 0 full load, 1 abort at word stop_k, 2 reset at word stop_k.
    task automatic run_load(input logic [31:0] base, input bit gaps, input int kind,
                            input int stop_k, input int start_k);
        exp_t nx;
        int   k = 0;
        int   guard = 0;
        bit   tog = 1'b0;
        bit   fin = 1'b0;
        build(base, nx);
        nx.ch = ~cur_ch;
        @(negedge clk); i_start = 1'b1;
        while (!fin && guard < 300) begin
            @(negedge clk);
            guard++;
            i_start = (k == start_k);
            if (gaps && tog) begin
                i_s_valid = 1'b0;
                tog = 1'b0;
            end else begin
                i_s_valid = 1'b1;
                i_s_data  = base + 32'(k);
                if (o_s_ready === 1'b1) begin
                    tog = 1'b1;
                    if (kind != 0 && k == stop_k) begin
                        if (kind == 1) i_abort = 1'b1;
                        else           i_rst   = 1'b1;
                        fin = 1'b1;
                    end else if (k == 62) begin
                        chk("old_choice", 864'(o_choice), 864'(cur_ch));
                        chk("old_wg3", o_wg3, cur.wg3);
                        chk("old_wd3", 864'(o_wd3), 864'(cur.wd3));
                        nx.cyc = cyc + 1;
                        sb.push_back(nx);
                        fin = 1'b1;
                    end
                    k++;
                end
            end
        end
        chk("load_progress", 864'(fin), 864'd1);
        @(negedge clk);
        i_s_valid = 1'b0; i_abort = 1'b0; i_rst = 1'b0; i_start = 1'b0;
        if (kind == 0) begin
            cur = nx; cur_ch = nx.ch;
        end else if (kind == 2) begin
            build(32'd0, cur);
            cur.wg2 = '0; cur.wg3 = '0; cur.wd2 = '0; cur.wd3 = '0;
            cur_ch = 1'b0;
        end
    endtask

    initial begin
        cur.wg2 = '0; cur.wg3 = '0; cur.wd2 = '0; cur.wd3 = '0; cur.ch = 1'b0; cur.cyc = 0;
        cur_ch = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_choice", 864'(o_choice), 864'd0);
        chk("rst_ready", 864'(o_s_ready), 864'd0);
        chk("rst_busy", 864'(o_busy), 864'd0);
        chk("rst_done", 864'(o_done), 864'd0);
        chk("rst_wg2", 864'(o_wg2), 864'd0);
        chk("rst_wg3", o_wg3, 864'd0);
        chk("rst_wd2", o_wd2, 864'd0);
        chk("rst_wd3", 864'(o_wd3), 864'd0);
        i_rst = 1'b0;

        // Scenario 1: contiguous load.
        run_load(32'h1000_0000, 1'b0, 0, -1, -1);
        chk("s1_choice", 864'(o_choice), 864'd1);
        chk("s1_wg2_w0", 864'(o_wg2[31:0]), 864'h1000_0000);
        chk("s1_wg3_w0", 864'(o_wg3[31:0]), 864'h1000_0006);
        chk("s1_wd2_w0", 864'(o_wd2[31:0]), 864'h1000_0021);
        chk("s1_wd3_w2", 864'(o_wd3[95:64]), 864'h1000_003E);

        // Scenario 3: second load flips back to bank 0.
        run_load(32'hA000_0000, 1'b0, 0, -1, -1);
        chk("s3_choice", 864'(o_choice), 864'd0);
        chk("s3_wg2_w1", 864'(o_wg2[63:32]), 864'hA000_0001);

        // Scenario 2: valid toggling 1-0-1-0.
        run_load(32'h1000_0000, 1'b1, 0, -1, -1);
        chk("s2_choice", 864'(o_choice), 864'd1);
        chk("s2_wg2_w0", 864'(o_wg2[31:0]), 864'h1000_0000);
        chk("s2_wd3_w2", 864'(o_wd3[95:64]), 864'h1000_003E);

        // Scenario 4: abort on word 15, then a clean reload.
        run_load(32'h3000_0000, 1'b0, 1, 15, -1);
        chk("s4_busy", 864'(o_busy), 864'd0);
        chk("s4_choice", 864'(o_choice), 864'(cur_ch));
        chk("s4_wg2", 864'(o_wg2), 864'(cur.wg2));
        chk("s4_wg3", o_wg3, cur.wg3);
        run_load(32'h4000_0000, 1'b0, 0, -1, -1);
        chk("s4_reload_wg2_w0", 864'(o_wg2[31:0]), 864'h4000_0000);

        // Scenario 5: start during WD2 is ignored, abort in IDLE is ignored,
        // abort on the last word suppresses the swap.
        run_load(32'h5000_0000, 1'b0, 0, -1, 40);
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
        chk("s5_idle_abort_busy", 864'(o_busy), 864'd0);
        chk("s5_idle_abort_done", 864'(o_done), 864'd0);
        chk("s5_idle_abort_choice", 864'(o_choice), 864'(cur_ch));
        run_load(32'h6000_0000, 1'b0, 1, 62, -1);
        chk("s5_last_abort_choice", 864'(o_choice), 864'(cur_ch));
        chk("s5_last_abort_busy", 864'(o_busy), 864'd0);
        chk("s5_last_abort_wd3", 864'(o_wd3), 864'(cur.wd3));
        chk("s5_last_abort_wg2", 864'(o_wg2), 864'(cur.wg2));
        repeat (3) @(negedge clk);

        // Scenario 6: reset in the middle of WD2.
        run_load(32'h7000_0000, 1'b0, 2, 45, -1);
        chk("s6_choice", 864'(o_choice), 864'd0);
        chk("s6_wg2", 864'(o_wg2), 864'd0);
        chk("s6_wg3", o_wg3, 864'd0);
        chk("s6_wd2", o_wd2, 864'd0);
        chk("s6_wd3", 864'(o_wd3), 864'd0);
        chk("s6_ready", 864'(o_s_ready), 864'd0);
        chk("s6_busy", 864'(o_busy), 864'd0);
        run_load(32'h8000_0000, 1'b0, 0, -1, -1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drained", 864'(sb.size()), 864'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
